put_get_arbiter: RTL and testbench
==================================

Name: put_get_arbiter

Overview:
- Shares one mkHardware-style put/get channel (EN_/RDY_ method handshake) among N independent requesters.
- Put side: round-robin arbitration; the winner's datum is forwarded to EN_put/put_datas.
- Get side: each result from the shared block is routed back to the requester that issued the matching put. Routing uses an in-order tag FIFO, because the shared block returns exactly one result per put, in put order.

Parameters:
- N, 4, number of requesters (2..8)
- W, 32, data width of put and get payloads
- D, 8, tag FIFO depth = maximum outstanding puts (power of 2, >=2)

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  synchronous active-low reset
- req_valid  in  N  requester i has a datum to put
- req_data  in  N*W  requester i payload in bits [i*W +: W]
- req_ready  out  N  one-hot; requester i's datum accepted this cycle
- rsp_valid  out  N  one-hot; result for requester i available
- rsp_data  out  W  result payload (shared by all requesters)
- rsp_ready  in  N  requester i can take its result
- EN_put  out  1  put enable to shared block
- put_datas  out  W  put payload to shared block
- RDY_put  in  1  shared block can accept put
- EN_get  out  1  get enable to shared block
- get  in  W  shared block result
- RDY_get  in  1  shared block result available
- outstanding  out  clog2(D+1)  puts issued with results not yet delivered

Behaviour:
- Clock and reset: single clock CLK. Reset is synchronous, active-low on RST_N, sampled at the rising edge. Upstream drives RST_N low for at least 5 cycles.
- Reset state: rr_ptr=0, tag FIFO empty, outstanding=0.
- Outputs during and just after reset: req_ready, rsp_valid, EN_put and EN_get are all 0. put_datas and rsp_data are 0 while the FIFO is empty or no grant exists.

Put arbitration (combinational grant, registered pointer):
- eligible = RDY_put && !fifo_full && |req_valid.
- Winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo N.
- When eligible: req_ready = onehot(winner), EN_put=1, put_datas = req_data[winner].
- Otherwise req_ready=0, EN_put=0.
- On a put fire: rr_ptr <= (winner+1) mod N, and winner index is pushed into the tag FIFO.
- req_data must stay stable while req_valid is high and not accepted. The arbiter may grant a different requester meanwhile.
- Fairness: with all N requesters valid continuously, each is granted exactly once every N fires.

Get routing:
- head = tag FIFO head index.
- rsp_valid[head] = RDY_get && !fifo_empty; all other bits are 0. rsp_data = get.
- EN_get = RDY_get && !fifo_empty && rsp_ready[head]. A fire pops the FIFO.
- RDY_get while the FIFO is empty is ignored: EN_get stays 0. Flag an assertion in simulation.

Tag FIFO and outstanding count:
- Depth D, width clog2(N).
- Push is blocked when full, even if a pop happens in the same cycle (no full-bypass).
- No empty-bypass: a tag pushed in cycle t is first eligible for routing in cycle t+1.
- Simultaneous push and pop when neither full nor empty: both take effect; count unchanged.
- Read and write pointers wrap modulo D.
- outstanding = FIFO occupancy, registered. Range 0..D; never exceeds D, never underflows.

Reset mid-operation:
- Asserting RST_N flushes the FIFO, zeroes outstanding, and resets rr_ptr to 0 on that edge.
- The shared block is reset by the same RST_N, so in-flight results are discarded.

Latency:
- Arbitration and routing add zero cycles.
- A requester's result appears no earlier than one cycle after its put fires.

Test Plan:
1. Reset: hold RST_N=0 for 5 cycles with all req_valid=1 and RDY_put=1 -> EN_put=0, req_ready=0, outstanding=0 throughout; first fire after release grants requester 0.
2. Round-robin: N=4, all req_valid=1, RDY_put=1, RDY_get=0 -> grants 0,1,2,3,0,1,2,3 and stops after 8 fires; outstanding=8 and EN_put=0 while full.
3. Routing: puts from requesters 2,0,3 with data 4,8,12; shared block echoes input; RDY_get=1; all rsp_ready=1 -> rsp_valid one-hot 4'b0100, 4'b0001, 4'b1000 with rsp_data 4,8,12; outstanding returns to 0.
4. Backpressure: head tag=1 with rsp_ready[1]=0 for 3 cycles while RDY_get=1 -> EN_get=0 and rsp_valid=4'b0010 held for 3 cycles; single pop when rsp_ready[1] rises.
5. Full with simultaneous pop: outstanding=8, req_valid=1, RDY_put=1, EN_get fires -> no push that cycle, outstanding=7; push occurs next cycle, outstanding=8.
6. Random soak: randomized RDY_put, RDY_get, req_valid and rsp_ready over 1000 cycles, with an in-order add-4 shared-block model -> every result reaches its issuer in order and no assertion fires.

Source files
------------

// File: rtl/put_get_arbiter.sv
// put_get_arbiter: shares one EN_/RDY_ put/get channel among N requesters.
// Puts are granted round-robin; each get result is steered back to the
// requester that issued the matching put, using an in-order tag FIFO that
// records the winner index of every put still awaiting its result.
//
// Handshake semantics (all channels): a transfer happens on a rising CLK edge
// exactly when the producer's valid/RDY and the consumer's ready/EN are both
// high in that cycle. Producers hold data stable while valid is high and the
// transfer has not yet happened; valid never waits on ready.
module put_get_arbiter #(
    parameter int N = 4,
    parameter int W = 32,
    parameter int D = 8
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [N-1:0]           req_valid,
    input  logic [N*W-1:0]         req_data,
    output logic [N-1:0]           req_ready,
    output logic [N-1:0]           rsp_valid,
    output logic [W-1:0]           rsp_data,
    input  logic [N-1:0]           rsp_ready,
    output logic                   EN_put,
    output logic [W-1:0]           put_datas,
    input  logic                   RDY_put,
    output logic                   EN_get,
    input  logic [W-1:0]           get,
    input  logic                   RDY_get,
    output logic [$clog2(D+1)-1:0] outstanding
);

    localparam int TW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = $clog2(D);
    localparam int CW = $clog2(D + 1);

    logic [TW-1:0] rr_ptr_q, rr_ptr_d;
    logic [TW-1:0] tag_mem_q [D];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          fifo_full;
    logic          fifo_empty;
    logic          eligible;
    logic          found;
    logic [TW-1:0] winner;
    logic [TW-1:0] cand;
    logic [TW-1:0] head;
    logic          get_avail;

    assign fifo_full  = (count_q == CW'(D));
    assign fifo_empty = (count_q == '0);
    assign head       = tag_mem_q[rd_ptr_q];

    // Reset gates every grant so nothing leaks out while RST_N is low.
    assign eligible  = RST_N && RDY_put && !fifo_full && (|req_valid);
    assign get_avail = RST_N && RDY_get && !fifo_empty;

    // Round-robin search: first valid requester starting at rr_ptr, wrapping mod N.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < N; k++) begin
            cand = TW'((int'(rr_ptr_q) + k) % N);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign req_ready = eligible ? (N'(1) << winner) : '0;
    assign EN_put    = eligible;
    assign put_datas = eligible ? req_data[int'(winner)*W +: W] : '0;

    // Results always belong to the oldest outstanding put, i.e. the FIFO head.
    assign rsp_valid = get_avail ? (N'(1) << head) : '0;
    assign EN_get    = get_avail && rsp_ready[head];
    assign rsp_data  = (RST_N && !fifo_empty) ? get : '0;

    assign outstanding = count_q;

    // Next-state for pointer, FIFO pointers and occupancy. Push is already
    // blocked when full (via eligible), and pop needs a non-empty FIFO, so the
    // count can neither overflow nor underflow.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (EN_put) begin
            rr_ptr_d = (winner == TW'(N - 1)) ? '0 : winner + 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (EN_get) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({EN_put, EN_get})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state with synchronous active-low reset; a mid-run reset flushes the FIFO.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Tag storage: the winner index is written at the tail on every put fire.
    always_ff @(posedge CLK) begin
        if (EN_put) begin
            tag_mem_q[wr_ptr_q] <= winner;
        end
    end

    // A result offered with no put outstanding means the shared block misbehaved.
    a_get_while_empty: assert property (@(posedge CLK) disable iff (!RST_N)
        !(RDY_get && fifo_empty));

endmodule

// File: tb/tb_put_get_arbiter.sv
// Bench for put_get_arbiter: cycle-by-cycle vector table, a hand-written
// routing sequence, and a randomized soak against an in-order add-4 block.
module tb_put_get_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int D = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic [N-1:0]   rsp_ready;
    logic           EN_put;
    logic [W-1:0]   put_datas;
    logic           RDY_put;
    logic           EN_get;
    logic [W-1:0]   get;
    logic           RDY_get;
    logic [3:0]     outstanding;

    int n_vec  = 0;
    int n_miss = 0;

    logic [W-1:0] rd [N];
    logic [W-1:0] exp_q[$];
    int           exp_tag[$];
    int           rr_m;
    int           w;
    logic         elig;
    logic         hv;
    logic         e_eg;
    logic [N-1:0] e_rv;
    logic [N-1:0] e_rdy;

    typedef struct {
        logic         rst_n;
        logic [3:0]   valid;
        logic         rdy_put;
        logic         rdy_get;
        logic [3:0]   rsp_rdy;
        logic [31:0]  get;
        logic [3:0]   e_ready;
        logic         e_put;
        logic [31:0]  e_pdata;
        logic [3:0]   e_rvalid;
        logic         e_get;
        logic [31:0]  e_rdata;
        logic [3:0]   e_out;
    } vec_t;

    vec_t tbl [29];

    put_get_arbiter #(.N(N), .W(W), .D(D)) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_ready   (rsp_ready),
        .EN_put      (EN_put),
        .put_datas   (put_datas),
        .RDY_put     (RDY_put),
        .EN_get      (EN_get),
        .get         (get),
        .RDY_get     (RDY_get),
        .outstanding (outstanding)
    );

    // Clock and reset-free clock generator.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < N; i++) req_data[i*W +: W] = rd[i];
    endtask

    task automatic set_data(input int i, input logic [W-1:0] v);
        rd[i] = v;
        drive_data();
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic rp, input logic rg,
                                input logic [3:0] rr, input logic [31:0] g,
                                input logic [3:0] er, input logic ep, input logic [31:0] ed,
                                input logic [3:0] ev, input logic eg, input logic [31:0] erd,
                                input logic [3:0] eo);
        vec_t t;
        t.rst_n = r; t.valid = v; t.rdy_put = rp; t.rdy_get = rg; t.rsp_rdy = rr; t.get = g;
        t.e_ready = er; t.e_put = ep; t.e_pdata = ed; t.e_rvalid = ev; t.e_get = eg;
        t.e_rdata = erd; t.e_out = eo;
        return t;
    endfunction

    initial begin
        // Requester i offers 0xA0+i throughout the table.
        for (int k = 0; k < 5; k++) tbl[k] = mk(0, 4'hF, 1, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 4'hF, 1, 0, 4'hF, 0, 4'h1, 1, 32'hA0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 4'hF, 1, 0, 4'hF, 0, 4'h2, 1, 32'hA1, 0, 0, 0, 1);
        tbl[7]  = mk(1, 4'hF, 1, 0, 4'hF, 0, 4'h4, 1, 32'hA2, 0, 0, 0, 2);
        tbl[8]  = mk(1, 4'hF, 1, 0, 4'hF, 0, 4'h8, 1, 32'hA3, 0, 0, 0, 3);
        tbl[9]  = mk(1, 4'hF, 1, 0, 4'hF, 0, 4'h1, 1, 32'hA0, 0, 0, 0, 4);
        tbl[10] = mk(1, 4'hF, 1, 0, 4'hF, 0, 4'h2, 1, 32'hA1, 0, 0, 0, 5);
        tbl[11] = mk(1, 4'hF, 1, 0, 4'hF, 0, 4'h4, 1, 32'hA2, 0, 0, 0, 6);
        tbl[12] = mk(1, 4'hF, 1, 0, 4'hF, 0, 4'h8, 1, 32'hA3, 0, 0, 0, 7);
        tbl[13] = mk(1, 4'hF, 1, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 8);
        // Full with a simultaneous pop: no push this cycle, push on the next.
        tbl[14] = mk(1, 4'hF, 1, 1, 4'hF, 32'h55, 0, 0, 0, 4'h1, 1, 32'h55, 8);
        tbl[15] = mk(1, 4'hF, 1, 0, 4'hF, 0, 4'h1, 1, 32'hA0, 0, 0, 0, 7);
        tbl[16] = mk(1, 4'hF, 1, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 8);
        // Head tag 1 backpressured for three cycles, then a single pop.
        for (int k = 17; k < 20; k++)
            tbl[k] = mk(1, 4'hF, 1, 1, 4'hD, 32'h77, 0, 0, 0, 4'h2, 0, 32'h77, 8);
        tbl[20] = mk(1, 4'hF, 1, 1, 4'hF, 32'h77, 0, 0, 0, 4'h2, 1, 32'h77, 8);
        tbl[21] = mk(1, 4'h0, 1, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 7);
        // Mid-run reset: flush on the edge, then pointer restarts at 0.
        tbl[22] = mk(0, 4'hF, 1, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 7);
        tbl[23] = mk(1, 4'h4, 1, 0, 4'hF, 0, 4'h4, 1, 32'hA2, 0, 0, 0, 0);
        tbl[24] = mk(1, 4'h0, 1, 1, 4'hF, 32'h99, 0, 0, 0, 4'h4, 1, 32'h99, 1);
        tbl[25] = mk(1, 4'h0, 1, 0, 4'hF, 32'h12, 0, 0, 0, 0, 0, 0, 0);
        tbl[26] = mk(1, 4'hB, 1, 0, 4'hF, 0, 4'h8, 1, 32'hA3, 0, 0, 0, 0);
        tbl[27] = mk(1, 4'h3, 1, 0, 4'hF, 0, 4'h1, 1, 32'hA0, 0, 0, 0, 1);
        tbl[28] = mk(1, 4'h3, 0, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 2);

        for (int i = 0; i < N; i++) rd[i] = 32'hA0 + i;
        drive_data();
        rst_n = 0; req_valid = 4'hF; RDY_put = 1; RDY_get = 0; rsp_ready = 4'hF; get = 0;
        tick();

        for (int k = 0; k < 29; k++) begin
            rst_n = tbl[k].rst_n; req_valid = tbl[k].valid; RDY_put = tbl[k].rdy_put;
            RDY_get = tbl[k].rdy_get; rsp_ready = tbl[k].rsp_rdy; get = tbl[k].get;
            @(negedge clk);
            check($sformatf("v%0d_req_ready", k), req_ready, tbl[k].e_ready);
            check($sformatf("v%0d_en_put", k), EN_put, tbl[k].e_put);
            check($sformatf("v%0d_put_datas", k), put_datas, tbl[k].e_pdata);
            check($sformatf("v%0d_rsp_valid", k), rsp_valid, tbl[k].e_rvalid);
            check($sformatf("v%0d_en_get", k), EN_get, tbl[k].e_get);
            check($sformatf("v%0d_rsp_data", k), rsp_data, tbl[k].e_rdata);
            check($sformatf("v%0d_outstanding", k), outstanding, tbl[k].e_out);
            tick();
        end

        // Routing: puts from 2,0,3 carrying 4,8,12; block echoes them back.
        rst_n = 0; req_valid = 0; RDY_put = 1; RDY_get = 0; rsp_ready = 4'hF; get = 0;
        repeat (5) tick();
        rst_n = 1;
        req_valid = 4'b0100; set_data(2, 32'd4);
        @(negedge clk);
        check("rt_grant0", req_ready, 4'b0100);
        check("rt_put0", put_datas, 32'd4);
        tick();
        req_valid = 4'b0001; set_data(0, 32'd8);
        @(negedge clk);
        check("rt_grant1", req_ready, 4'b0001);
        check("rt_put1", put_datas, 32'd8);
        tick();
        req_valid = 4'b1000; set_data(3, 32'd12);
        @(negedge clk);
        check("rt_grant2", req_ready, 4'b1000);
        check("rt_put2", put_datas, 32'd12);
        tick();
        req_valid = 0; RDY_get = 1; get = 32'd4;
        @(negedge clk);
        check("rt_rv0", rsp_valid, 4'b0100);
        check("rt_rd0", rsp_data, 32'd4);
        check("rt_eg0", EN_get, 1'b1);
        check("rt_out0", outstanding, 3);
        tick();
        get = 32'd8;
        @(negedge clk);
        check("rt_rv1", rsp_valid, 4'b0001);
        check("rt_rd1", rsp_data, 32'd8);
        check("rt_out1", outstanding, 2);
        tick();
        get = 32'd12;
        @(negedge clk);
        check("rt_rv2", rsp_valid, 4'b1000);
        check("rt_rd2", rsp_data, 32'd12);
        check("rt_out2", outstanding, 1);
        tick();
        RDY_get = 0; get = 0;
        @(negedge clk);
        check("rt_out_final", outstanding, 0);
        check("rt_rv_final", rsp_valid, 4'b0000);
        tick();

        // Random soak against an in-order add-4 shared block.
        rst_n = 0; req_valid = 0; RDY_put = 0; RDY_get = 0; rsp_ready = 0; get = 0;
        repeat (5) tick();
        rst_n = 1;
        exp_q.delete();
        exp_tag.delete();
        rr_m = 0;
        for (int c = 0; c < 1000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
                    req_valid[i] = 1'b1;
                    rd[i] = $urandom;
                end
            end
            drive_data();
            RDY_put   = ($urandom_range(0, 3) != 0);
            RDY_get   = (exp_q.size() > 0) && ($urandom_range(0, 2) != 0);
            get       = (exp_q.size() > 0) ? exp_q[0] : W'($urandom);
            rsp_ready = N'($urandom_range(0, 15));
            @(negedge clk);

            elig = RDY_put && (exp_tag.size() < D) && (|req_valid);
            w = 0;
            if (elig) begin
                for (int k = N - 1; k >= 0; k--)
                    if (req_valid[(rr_m + k) % N]) w = (rr_m + k) % N;
            end
            e_rdy = elig ? (N'(1) << w) : '0;
            check($sformatf("soak%0d_req_ready", c), req_ready, e_rdy);
            check($sformatf("soak%0d_en_put", c), EN_put, elig);
            check($sformatf("soak%0d_put_datas", c), put_datas, elig ? rd[w] : '0);

            hv   = (exp_tag.size() > 0);
            e_rv = (RDY_get && hv) ? (N'(1) << exp_tag[0]) : '0;
            e_eg = RDY_get && hv && rsp_ready[hv ? exp_tag[0] : 0];
            check($sformatf("soak%0d_rsp_valid", c), rsp_valid, e_rv);
            check($sformatf("soak%0d_en_get", c), EN_get, e_eg);
            check($sformatf("soak%0d_rsp_data", c), rsp_data, hv ? exp_q[0] : '0);
            check($sformatf("soak%0d_outstanding", c), outstanding, exp_tag.size());

            if (e_eg) begin
                void'(exp_q.pop_front());
                void'(exp_tag.pop_front());
            end
            if (elig) begin
                exp_q.push_back(rd[w] + 32'd4);
                exp_tag.push_back(w);
                rr_m = (w + 1) % N;
            end
            tick();
            if (elig) req_valid[w] = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
